micro_pc_sequencer: RTL and testbench
=====================================

Name: micro_pc_sequencer

Overview:
- Microprogram counter (mPC) and step decoder for the hard-wired/microcoded picoRISC control unit.
- Consumes the branch controls and one-hot branch-target vector from the translate-control stage, plus the opcode and addressing-mode dispatch addresses from the instruction decoder.
- Each clock it selects the next micro-address, registers it, and decodes it to the one-hot step bus T[255:0], which feeds back into translate control and the datapath signal generators.

Parameters:
- MPC_W, 8, micro-address width (T width = 2**MPC_W)
- T_W, 256, step-bus width; must equal 2**MPC_W

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- hold  in  1  freeze mPC this cycle (memory/bus wait)
- bropr  in  1  dispatch on opcode: next = mop
- bradr  in  1  dispatch on addressing mode: next = madr
- bruncnd  in  1  unconditional jump to target
- brcnd  in  1  conditional jump already qualified; taken when 1
- signals  in  16  target one-hot; bits 15..10 = targets 0, 8, 17, 19, 41, 49; bits 9..0 reserved
- mop  in  MPC_W  opcode dispatch address
- madr  in  MPC_W  addressing-mode dispatch address
- mpc  out  MPC_W  current micro-address (registered)
- T  out  T_W  one-hot decode of mpc
- seq_err  out  1  sticky sequencing-error flag

Behaviour:
- Reset (rst_n=0 at rising edge): mpc=0, seq_err=0, so T=1 (T[0]=1). Reset wins over hold and all branch inputs.
- Target encode from signals[15:10]:
  - Fixed priority, highest bit first: 15→0, 14→8, 13→17, 12→19, 11→41, 10→49.
  - No bit set → target=0.
- Next-address priority, evaluated when hold=0:
  1. bropr → mop
  2. bradr → madr
  3. bruncnd or brcnd → encoded target
  4. otherwise → mpc+1, modulo 2**MPC_W
- hold=1: mpc keeps its value and all branch inputs are ignored. T is unchanged.
- Latency: next address is selected combinationally in cycle n. mpc and T show it from edge n+1. T is a pure combinational decode of the registered mpc; there is no extra register stage.
- T is always exactly one-hot. T[i]=1 iff mpc==i.
- seq_err is sticky and cleared only by reset. It sets at the edge where hold=0 and any of the following holds:
  - (a) more than one of bropr, bradr, (bruncnd|brcnd) is asserted;
  - (b) bruncnd|brcnd=1 and signals[15:10]==0;
  - (c) more than one bit of signals[15:10] is set while a jump is taken;
  - (d) the increment path is taken with mpc=2**MPC_W-1 (wrap to 0).
- After an error the selection result still follows the priority rules; seq_err is only a flag.
- Reserved bits signals[9:0] are ignored.
- Reset asserted mid-dispatch or mid-hold: mpc=0 on that edge, and sequencing restarts at step 0 the next cycle.

Optional Feature:
- Macro MPC_TRACE_EN.
- Defined: adds outputs step_cnt (16 bits) and last_tgt (MPC_W bits), both reset to 0.
  - step_cnt increments, wrapping, on every edge with rst_n=1 and hold=0.
  - last_tgt captures the selected next address on every edge where any branch (bropr/bradr/bruncnd/brcnd) is taken with hold=0.
- Undefined: both ports and their registers are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 for 2 clocks with bropr=1, mop=0x50 → mpc=0, T=1, seq_err=0. Release and drive idle inputs → mpc steps 1, 2, 3 and T[3]=1.
- Conditional jump: at mpc=4 drive brcnd=1, signals=0x4000 → mpc=8 next cycle. With brcnd=0 instead → mpc=5.
- Dispatch: bropr=1, mop=0x3C → mpc=0x3C, T[60]=1. Then bradr=1, madr=0x22 → mpc=0x22.
- Priority and error: bropr=1, bruncnd=1, mop=0x70, signals=0x0400 → mpc=0x70 and seq_err=1. seq_err stays 1 until rst_n=0.
- Hold: at mpc=9 assert hold=1 for 3 cycles with bruncnd=1, signals=0x0800 → mpc stays 9. On release with the same inputs → mpc=41.
- Wrap: force mpc to 255 via mop=0xFF, then idle → mpc=0, T[0]=1, seq_err=1. With MPC_TRACE_EN, step_cnt counts 2 over those two un-held edges and last_tgt=0xFF.

Source files
------------

// File: rtl/micro_pc_sequencer.sv
// Microprogram counter with branch/dispatch selection and one-hot step decode T.
// Optional MPC_TRACE_EN adds step_cnt and last_tgt trace outputs.
module micro_pc_sequencer #(
    parameter int MPC_W = 8,
    parameter int T_W   = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hold,
    input  logic             bropr,
    input  logic             bradr,
    input  logic             bruncnd,
    input  logic             brcnd,
    input  logic [15:0]      signals,
    input  logic [MPC_W-1:0] mop,
    input  logic [MPC_W-1:0] madr,
    output logic [MPC_W-1:0] mpc,
    output logic [T_W-1:0]   T,
    output logic             seq_err
`ifdef MPC_TRACE_EN
    ,
    output logic [15:0]      step_cnt,
    output logic [MPC_W-1:0] last_tgt
`endif
);

    logic [MPC_W-1:0] mpc_reg;
    logic [MPC_W-1:0] mpc_next;
    logic [MPC_W-1:0] target;
    logic             seq_err_reg;
    logic             err_now;
    logic             jump;
    logic             multi_src;
    logic             multi_bit;
    logic             incr_path;
    logic [5:0]       tgt_bits;
    logic             unused_reserved;

    assign tgt_bits        = signals[15:10];
    assign unused_reserved = ^signals[9:0];
    assign jump            = bruncnd | brcnd;
    assign multi_src       = (bropr & bradr) | (bropr & jump) | (bradr & jump);
    assign multi_bit       = (tgt_bits & (tgt_bits - 6'd1)) != 6'd0;
    assign incr_path       = ~bropr & ~bradr & ~jump;

    // Highest set bit wins; no bit set falls back to step 0.
    always_comb begin
        target = '0;
        if (tgt_bits[5])      target = MPC_W'(0);
        else if (tgt_bits[4]) target = MPC_W'(8);
        else if (tgt_bits[3]) target = MPC_W'(17);
        else if (tgt_bits[2]) target = MPC_W'(19);
        else if (tgt_bits[1]) target = MPC_W'(41);
        else if (tgt_bits[0]) target = MPC_W'(49);
    end

    always_comb begin
        mpc_next = mpc_reg + MPC_W'(1);
        if (bropr)      mpc_next = mop;
        else if (bradr) mpc_next = madr;
        else if (jump)  mpc_next = target;
    end

    assign err_now = multi_src
                   | (jump & (tgt_bits == 6'd0))
                   | (jump & multi_bit)
                   | (incr_path & (mpc_reg == '1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mpc_reg     <= '0;
            seq_err_reg <= 1'b0;
        end else if (!hold) begin
            mpc_reg     <= mpc_next;
            seq_err_reg <= seq_err_reg | err_now;
        end
    end

    assign mpc     = mpc_reg;
    assign seq_err = seq_err_reg;

    genvar gi;
    generate
        for (gi = 0; gi < T_W; gi++) begin : g_decode
            assign T[gi] = (mpc_reg == MPC_W'(gi));
        end
    endgenerate

`ifdef MPC_TRACE_EN
    logic [15:0]      step_cnt_reg;
    logic [MPC_W-1:0] last_tgt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            step_cnt_reg <= '0;
            last_tgt_reg <= '0;
        end else if (!hold) begin
            step_cnt_reg <= step_cnt_reg + 16'd1;
            if (!incr_path)
                last_tgt_reg <= mpc_next;
        end
    end

    assign step_cnt = step_cnt_reg;
    assign last_tgt = last_tgt_reg;
`endif

endmodule

// File: tb/tb_micro_pc_sequencer.sv
// Scoreboard bench for micro_pc_sequencer: directed vectors push expectations, a monitor checks mpc/T/seq_err.
module tb_micro_pc_sequencer;

    localparam int MPC_W = 8;
    localparam int T_W   = 256;

    logic             clk = 1'b0;
    logic             rst_n, hold, bropr, bradr, bruncnd, brcnd;
    logic [15:0]      signals;
    logic [MPC_W-1:0] mop, madr;
    logic [MPC_W-1:0] mpc;
    logic [T_W-1:0]   T;
    logic             seq_err;
`ifdef MPC_TRACE_EN
    logic [15:0]      step_cnt;
    logic [MPC_W-1:0] last_tgt;
`endif

    micro_pc_sequencer #(.MPC_W(MPC_W), .T_W(T_W)) dut (
        .clk(clk), .rst_n(rst_n), .hold(hold), .bropr(bropr), .bradr(bradr),
        .bruncnd(bruncnd), .brcnd(brcnd), .signals(signals), .mop(mop), .madr(madr),
        .mpc(mpc), .T(T), .seq_err(seq_err)
`ifdef MPC_TRACE_EN
        , .step_cnt(step_cnt), .last_tgt(last_tgt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [MPC_W-1:0] mpc;
        logic             err;
        logic [15:0]      cnt;
        logic [MPC_W-1:0] tgt;
        string            name;
    } exp_s;

    exp_s sb[$];
    int vectors     = 0;
    int miscompares = 0;
    logic [15:0]      model_cnt = '0;
    logic [MPC_W-1:0] model_tgt = '0;

    task automatic apply(input logic r, input logic h, input logic op, input logic ad,
                         input logic un, input logic cn, input logic [15:0] s,
                         input logic [MPC_W-1:0] m, input logic [MPC_W-1:0] a,
                         input logic [MPC_W-1:0] e_mpc, input logic e_err, input string name);
        exp_s e;
        @(negedge clk);
        rst_n = r; hold = h; bropr = op; bradr = ad; bruncnd = un; brcnd = cn;
        signals = s; mop = m; madr = a;
        if (!r) begin
            model_cnt = '0;
            model_tgt = '0;
        end else if (!h) begin
            model_cnt = model_cnt + 16'd1;
            if (op | ad | un | cn) model_tgt = e_mpc;
        end
        e.mpc = e_mpc; e.err = e_err; e.cnt = model_cnt; e.tgt = model_tgt; e.name = name;
        sb.push_back(e);
    endtask

    task automatic idle(input logic [MPC_W-1:0] e_mpc, input logic e_err, input string name);
        apply(1, 0, 0, 0, 0, 0, 16'h0000, 8'h00, 8'h00, e_mpc, e_err, name);
    endtask

    initial begin : monitor
        exp_s e;
        logic [T_W-1:0] exp_t;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                exp_t = '0;
                exp_t[e.mpc] = 1'b1;
                vectors++;
                if (mpc !== e.mpc) begin
                    miscompares++;
                    $display("FAIL %s mpc: got %02h expected %02h", e.name, mpc, e.mpc);
                end
                vectors++;
                if (T !== exp_t) begin
                    miscompares++;
                    $display("FAIL %s T: got bit-count %0d, T[exp]=%b, expected one-hot at %0d",
                             e.name, $countones(T), T[e.mpc], e.mpc);
                end
                vectors++;
                if (seq_err !== e.err) begin
                    miscompares++;
                    $display("FAIL %s seq_err: got %b expected %b", e.name, seq_err, e.err);
                end
`ifdef MPC_TRACE_EN
                vectors++;
                if (step_cnt !== e.cnt) begin
                    miscompares++;
                    $display("FAIL %s step_cnt: got %0d expected %0d", e.name, step_cnt, e.cnt);
                end
                vectors++;
                if (last_tgt !== e.tgt) begin
                    miscompares++;
                    $display("FAIL %s last_tgt: got %02h expected %02h", e.name, last_tgt, e.tgt);
                end
`endif
                $display("vec %-12s mpc=%02h seq_err=%b", e.name, mpc, seq_err);
            end
        end
    end

    initial begin : stimulus
        rst_n = 0; hold = 0; bropr = 1; bradr = 0; bruncnd = 0; brcnd = 0;
        signals = '0; mop = 8'h50; madr = '0;

        // reset beats a pending dispatch
        apply(0, 0, 1, 0, 0, 0, 16'h0000, 8'h50, 8'h00, 8'h00, 0, "rst0");
        apply(0, 0, 1, 0, 0, 0, 16'h0000, 8'h50, 8'h00, 8'h00, 0, "rst1");
        idle(8'h01, 0, "inc1");
        idle(8'h02, 0, "inc2");
        idle(8'h03, 0, "inc3");
        idle(8'h04, 0, "inc4");
        apply(1, 0, 0, 0, 0, 1, 16'h4000, 8'h00, 8'h00, 8'h08, 0, "brcnd_t8");
        apply(1, 0, 0, 0, 1, 0, 16'h8000, 8'h00, 8'h00, 8'h00, 0, "unc_t0");
        idle(8'h01, 0, "inc1b");
        idle(8'h02, 0, "inc2b");
        idle(8'h03, 0, "inc3b");
        idle(8'h04, 0, "inc4b");
        apply(1, 0, 0, 0, 0, 0, 16'h4000, 8'h00, 8'h00, 8'h05, 0, "brcnd_nt");
        apply(1, 0, 1, 0, 0, 0, 16'h0000, 8'h3C, 8'h00, 8'h3C, 0, "disp_op");
        apply(1, 0, 0, 1, 0, 0, 16'h0000, 8'h00, 8'h22, 8'h22, 0, "disp_adr");
        apply(1, 0, 0, 0, 0, 1, 16'h2000, 8'h00, 8'h00, 8'd17, 0, "tgt17");
        apply(1, 0, 0, 0, 1, 0, 16'h1000, 8'h00, 8'h00, 8'd19, 0, "tgt19");
        apply(1, 0, 0, 0, 0, 1, 16'h0400, 8'h00, 8'h00, 8'd49, 0, "tgt49");
        apply(1, 0, 0, 0, 1, 0, 16'h4000, 8'h00, 8'h00, 8'd8, 0, "tgt8");
        idle(8'd9, 0, "inc9");
        apply(1, 1, 0, 0, 1, 0, 16'h0800, 8'h00, 8'h00, 8'd9, 0, "hold0");
        apply(1, 1, 0, 0, 1, 0, 16'h0800, 8'h00, 8'h00, 8'd9, 0, "hold1");
        apply(1, 1, 0, 0, 1, 0, 16'h0800, 8'h00, 8'h00, 8'd9, 0, "hold2");
        apply(1, 0, 0, 0, 1, 0, 16'h0800, 8'h00, 8'h00, 8'd41, 0, "hold_rel");
        apply(1, 0, 1, 0, 1, 0, 16'h0400, 8'h70, 8'h00, 8'h70, 1, "prio_err");
        idle(8'h71, 1, "sticky");
        apply(1, 1, 0, 0, 0, 0, 16'h0000, 8'h00, 8'h00, 8'h71, 1, "sticky_hold");
        apply(0, 1, 0, 0, 0, 0, 16'h0000, 8'h00, 8'h00, 8'h00, 0, "rst_in_hold");
        idle(8'h01, 0, "restart");
        apply(1, 0, 0, 0, 1, 0, 16'h03FF, 8'h00, 8'h00, 8'h00, 1, "no_tgt_err");
        apply(0, 0, 0, 0, 0, 0, 16'h0000, 8'h00, 8'h00, 8'h00, 0, "rst_b");
        apply(1, 0, 0, 0, 0, 1, 16'h0C00, 8'h00, 8'h00, 8'd41, 1, "multibit_err");
        apply(0, 0, 0, 0, 0, 0, 16'h0000, 8'h00, 8'h00, 8'h00, 0, "rst_c");
        apply(1, 0, 1, 0, 0, 0, 16'h0000, 8'hFF, 8'h00, 8'hFF, 0, "to_ff");
        idle(8'h00, 1, "wrap");
        idle(8'h01, 1, "post_wrap");

        begin
            int waited = 0;
            while (sb.size() > 0 && waited < 10) begin
                @(posedge clk);
                #2;
                waited++;
            end
        end
        if (sb.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
